// File: rtl/seq_arith_pkg.sv
// Shared encodings and defaults for the sequential arithmetic units
// (squarer and its companion integer square-root engine).
package seq_arith_pkg;

  localparam int W_ROOT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_square.sv
// Sequential shift-add squarer: one partial product per clock, 4-phase
// start/ack request, registered outputs.
module seq_square
  import seq_arith_pkg::*;
#(
  parameter int W = W_ROOT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [W-1:0]     R,
  output logic [2*W-1:0]   sq,
  output logic             ack,
  output logic             busy
);

  localparam int CW = $clog2(W) + 1;

  seq_state_e          state_q, state_d;
  logic [2*W-1:0]      mcand_q, mcand_d;
  logic [W-1:0]        mult_q,  mult_d;
  logic [2*W-1:0]      acc_q,   acc_d;
  logic [CW-1:0]       cnt_q,   cnt_d;
  logic [2*W-1:0]      sq_q,    sq_d;
  logic                ack_q,   ack_d;
  logic                busy_q,  busy_d;
  logic [2*W-1:0]      acc_sum;

  // This step's accumulator, also the final result on the last step.
  assign acc_sum = mult_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = {{W{1'b0}}, R};
          mult_d  = R;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          sq_d    = acc_sum;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requires start to drop before another request can be taken.
        if (!start) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign sq   = sq_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seq_square.sv
// Directed bench for seq_square (W=4): latency, handshake, sweep, reset abort.
module tb_seq_square;

  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   R = '0;
  logic [2*W-1:0] sq;
  logic           ack;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  seq_square #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .R(R),
    .sq(sq), .ack(ack), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue a request for r, swap R to r_late after acceptance, check latency and result.
  task automatic req(input logic [W-1:0] r, input logic [W-1:0] r_late,
                     input logic [2*W-1:0] exp, input string tag);
    start = 1'b1;
    R = r;
    step();
    acc_cyc = cyc;
    chk({tag, "_acc_busy"}, 32'(busy), 1);
    chk({tag, "_acc_ack"}, 32'(ack), 0);
    R = r_late;
    for (int i = 1; i < W; i++) begin
      step();
      chk({tag, "_calc_busy"}, 32'(busy), 1);
      chk({tag, "_calc_ack"}, 32'(ack), 0);
    end
    step();
    chk({tag, "_ack"}, 32'(ack), 1);
    chk({tag, "_busy_lo"}, 32'(busy), 0);
    chk({tag, "_sq"}, 32'(sq), 32'(exp));
    chk({tag, "_lat"}, 32'(cyc - acc_cyc), W);
  endtask

  task automatic drop(input string tag);
    start = 1'b0;
    step();
    chk({tag, "_ack_fall"}, 32'(ack), 0);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_sq", 32'(sq), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    step();
    Reset = 1'b0;
    step();
    chk("idle_ack", 32'(ack), 0);

    // Nominal: R=9, start held a few cycles after ack
    req(4'd9, 4'd9, 8'd81, "nom");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nom_hold_ack", 32'(ack), 1);
      chk("nom_hold_sq", 32'(sq), 81);
    end
    drop("nom");

    // Boundaries
    req(4'd0, 4'd0, 8'd0, "r0");
    step();
    chk("r0_hold_ack", 32'(ack), 1);
    drop("r0");
    req(4'd15, 4'd15, 8'd225, "r15");
    step();
    chk("r15_hold_ack", 32'(ack), 1);
    chk("r15_hold_sq", 32'(sq), 225);
    drop("r15");

    // Back-to-back sweep at minimum period
    for (int r = 0; r < 16; r++) begin
      req(4'(r), 4'(r), 8'(r * r), "sweep");
      if (r > 0) chk("sweep_period", 32'(acc_cyc - prev_acc), W + 2);
      prev_acc = acc_cyc;
      drop("sweep");
    end

    // Mid-calc reset: R=12 accepted, reset 2 cycles later
    start = 1'b1;
    R = 4'd12;
    step();
    chk("abort_acc_busy", 32'(busy), 1);
    step();
    step();
    Reset = 1'b1;
    #1;
    chk("abort_sq", 32'(sq), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_busy", 32'(busy), 0);
    start = 1'b0;
    step();
    chk("abort_hold_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_ack", 32'(ack), 0);
    end
    // start rises together with Reset release
    Reset = 1'b0;
    req(4'd5, 4'd5, 8'd25, "post_rst");
    drop("post_rst");

    // Handshake: R changes during CALC, start held 20 cycles after ack
    req(4'd3, 4'd7, 8'd9, "hs");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hs_hold_ack", 32'(ack), 1);
      chk("hs_no_busy", 32'(busy), 0);
      chk("hs_hold_sq", 32'(sq), 9);
    end
    drop("hs");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hs_idle_sq", 32'(sq), 9);
      chk("hs_idle_busy", 32'(busy), 0);
    end

    // Root cross-check against A=81
    req(4'd9, 4'd9, 8'd81, "xchk9");
    chk("xchk9_le_A", 32'(sq <= 8'd81), 1);
    drop("xchk9");
    req(4'd10, 4'd10, 8'd100, "xchk10");
    chk("xchk10_gt_A", 32'(sq > 8'd81), 1);
    drop("xchk10");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
